// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle between a producer/consumer and the sync_fifo_flags buffer.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 41,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with FWFT/standard read, programmable almost flags,
// occupancy output, synchronous flush and sticky overflow/underflow.
module sync_fifo_flags #(
  parameter int DATA_WIDTH   = 41,
  parameter int ADDR_WIDTH   = 4,
  parameter int FWFT         = 1,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_flags_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] L_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] L_AFULL  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] L_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] L_ONE    = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic [ADDR_WIDTH:0]   w_level_next;
  logic [ADDR_WIDTH:0]   w_ptr_diff;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // Flush dominates both requests: no accept and no error event that cycle.
  always_comb begin
    w_wr_acc     = bus.wr_en & ~r_full  & ~bus.flush;
    w_rd_acc     = bus.rd_en & ~r_empty & ~bus.flush;
    w_ovf_set    = bus.wr_en &  r_full  & ~bus.flush;
    w_udf_set    = bus.rd_en &  r_empty & ~bus.flush;
    w_level_next = r_level;
    if (bus.flush)
      w_level_next = '0;
    else if (w_wr_acc && !w_rd_acc)
      w_level_next = r_level + L_ONE;
    else if (!w_wr_acc && w_rd_acc)
      w_level_next = r_level - L_ONE;
  end

  assign w_wr_addr  = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
  assign w_ptr_diff = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + L_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + L_ONE;
    end
  end

  // Flags come straight from the next level so they are glitch-free registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_level  <= w_level_next;
      r_full   <= (w_level_next == L_DEPTH);
      r_empty  <= (w_level_next == '0);
      r_afull  <= (w_level_next >= L_AFULL);
      r_aempty <= (w_level_next <= L_AEMPTY);
      r_ovf    <= w_ovf_set | (r_ovf & ~bus.clr_err);
      r_udf    <= w_udf_set | (r_udf & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (w_ptr_diff == r_level);
  end

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.level        = r_level;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_valid = ~r_empty;
      assign bus.rd_data  = r_empty ? '0 : r_mem[w_rd_addr];
    end else begin : g_std
      logic                  r_rd_valid;
      logic [DATA_WIDTH-1:0] r_rd_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= r_mem[w_rd_addr];
        end
      end

      assign bus.rd_valid = r_rd_valid;
      assign bus.rd_data  = r_rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: an FWFT and a standard-mode instance share one stimulus stream.
module tb_sync_fifo_flags;
  localparam int DW = 41;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();

  assign if1.wr_en = wr_en;  assign if1.wr_data = wr_data; assign if1.rd_en = rd_en;
  assign if1.flush = flush;  assign if1.clr_err = clr_err;
  assign if0.wr_en = wr_en;  assign if0.wr_data = wr_data; assign if0.rd_en = rd_en;
  assign if0.flush = flush;  assign if0.clr_err = clr_err;

  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(if1));
  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2))
    u_std  (.clk(clk), .rst_n(rst_n), .bus(if0));

  // Reference model: contents as a queue, sticky errors, last popped word for standard mode.
  logic [DW-1:0] m_q[$];
  bit            m_ovf, m_udf, m_rdv0;
  logic [DW-1:0] m_rdd0;
  int            total = 0;
  int            bad = 0;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_udf = 0; m_rdv0 = 0; m_rdd0 = '0;
  endtask

  task automatic tick();
    bit wacc, racc, ovs, uds;
    int n;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      n    = m_q.size();
      ovs  = !flush && wr_en && (n == DEPTH);
      uds  = !flush && rd_en && (n == 0);
      wacc = !flush && wr_en && (n < DEPTH);
      racc = !flush && rd_en && (n > 0);
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
      if (ovs) m_ovf = 1;
      if (uds) m_udf = 1;
      m_rdv0 = racc;
      if (racc) m_rdd0 = m_q.pop_front();
      if (wacc) m_q.push_back(wr_data);
      if (flush) m_q.delete();
    end
    #1;
  endtask

  function automatic logic [10:0] exp_flags();
    int n = m_q.size();
    return {n == DEPTH, n == 0, n >= 12, n <= 2, m_ovf, m_udf, 5'(n)};
  endfunction

  function automatic logic [DW-1:0] exp_head();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  task automatic idle();
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    logic [10:0] want;
    rst_n = 0; idle();
    tick(); tick();
    want = 11'b0_1_0_1_0_0_00000;
    total++;
    if ({if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow, if1.level} !== want) begin
      bad++; $display("FAIL reset_flags_fwft got %b want %b",
        {if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow, if1.level}, want);
    end
    total++;
    if ({if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow, if0.level} !== want) begin
      bad++; $display("FAIL reset_flags_std got %b want %b",
        {if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow, if0.level}, want);
    end
    total++;
    if ({if1.rd_valid, if0.rd_valid, if1.rd_data, if0.rd_data} !== '0) begin
      bad++; $display("FAIL reset_rd got v1=%b v0=%b d1=%h d0=%h want all 0", if1.rd_valid, if0.rd_valid, if1.rd_data, if0.rd_data);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_data = DW'(32'h100 + i);
      tick();
      total++;
      if ({if1.level, if1.almost_empty, if1.almost_full, if1.full} !==
          {5'(i + 1), (i + 1) <= 2, (i + 1) >= 12, (i + 1) == 16}) begin
        bad++; $display("FAIL fill_%0d got lvl=%0d ae=%b af=%b f=%b want lvl=%0d", i, if1.level,
          if1.almost_empty, if1.almost_full, if1.full, i + 1);
      end
    end
    wr_data = DW'(32'h110);
    tick();
    total++;
    if ({if1.level, if1.overflow, if0.overflow} !== {5'd16, 1'b1, 1'b1}) begin
      bad++; $display("FAIL fill_overflow got lvl=%0d ovf=%b/%b want lvl=16 ovf=1", if1.level, if1.overflow, if0.overflow);
    end
    idle();
  endtask

  task automatic test_full_rw();
    wr_en = 1; rd_en = 1; wr_data = DW'(32'h3FF);
    tick();
    total++;
    if ({if1.level, if1.rd_data, if0.rd_valid, if0.rd_data} !== {5'd15, DW'(32'h101), 1'b1, DW'(32'h100)}) begin
      bad++; $display("FAIL full_rw got lvl=%0d head=%h v0=%b d0=%h want 15 101 1 100",
        if1.level, if1.rd_data, if0.rd_valid, if0.rd_data);
    end
    wr_en = 0;
    for (int i = 0; i < 5; i++) tick();
    rd_en = 0;
    total++;
    if (if1.level !== 5'd10) begin
      bad++; $display("FAIL drain_to_10 got %0d want 10", if1.level);
    end
  endtask

  task automatic test_flush();
    flush = 1; wr_en = 1; wr_data = DW'(32'h555);
    tick();
    idle();
    total++;
    if ({if1.level, if1.empty, if1.almost_empty, if1.overflow, if0.rd_valid} !== {5'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL flush got lvl=%0d e=%b ae=%b ovf=%b v0=%b want 0 1 1 1 0",
        if1.level, if1.empty, if1.almost_empty, if1.overflow, if0.rd_valid);
    end
    tick();
    total++;
    if (if1.empty !== 1'b1 || if1.rd_valid !== 1'b0) begin
      bad++; $display("FAIL flush_nothing_written got e=%b v=%b want 1 0", if1.empty, if1.rd_valid);
    end
    wr_en = 1;
    for (int i = 0; i < DEPTH; i++) begin wr_data = DW'(32'h600 + i); tick(); end
    clr_err = 1;
    tick();
    total++;
    if ({if1.overflow, if0.overflow} !== 2'b11) begin
      bad++; $display("FAIL clr_vs_set got %b%b want 11", if1.overflow, if0.overflow);
    end
    wr_en = 0;
    tick();
    clr_err = 0;
    total++;
    if ({if1.overflow, if0.overflow, if1.level} !== {2'b00, 5'd16}) begin
      bad++; $display("FAIL clr_err got ovf=%b%b lvl=%0d want 00 16", if1.overflow, if0.overflow, if1.level);
    end
  endtask

  task automatic test_fwft();
    flush = 1; tick(); flush = 0;
    wr_en = 1; wr_data = DW'(32'h0AA);
    tick();
    wr_en = 0;
    total++;
    if ({if1.rd_valid, if1.rd_data} !== {1'b1, DW'(32'h0AA)}) begin
      bad++; $display("FAIL fwft_fallthrough got v=%b d=%h want 1 0aa", if1.rd_valid, if1.rd_data);
    end
    rd_en = 1;
    tick();
    rd_en = 0;
    total++;
    if ({if1.empty, if1.rd_valid} !== 2'b10) begin
      bad++; $display("FAIL fwft_pop got e=%b v=%b want 1 0", if1.empty, if1.rd_valid);
    end
  endtask

  task automatic test_std();
    clr_err = 1; tick(); clr_err = 0;
    wr_en = 1;
    for (int i = 0; i < 3; i++) begin wr_data = DW'(32'h200 + i); tick(); end
    wr_en = 0;
    total++;
    if (if0.rd_valid !== 1'b0) begin
      bad++; $display("FAIL std_no_read_valid got %b want 0", if0.rd_valid);
    end
    rd_en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({if0.rd_valid, if0.rd_data} !== {1'b1, DW'(32'h200 + k)}) begin
        bad++; $display("FAIL std_read_%0d got v=%b d=%h want 1 %h", k, if0.rd_valid, if0.rd_data, 32'h200 + k);
      end
    end
    tick();
    rd_en = 0;
    total++;
    if ({if0.rd_valid, if0.underflow, if1.underflow, if0.rd_data} !== {1'b0, 1'b1, 1'b1, DW'(32'h202)}) begin
      bad++; $display("FAIL std_underflow got v=%b udf=%b/%b d=%h want 0 1 1 202",
        if0.rd_valid, if0.underflow, if1.underflow, if0.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    flush = 1; tick(); flush = 0;
    wr_en = 1;
    for (int i = 0; i < 8; i++) begin wr_data = DW'(32'h700 + i); tick(); end
    rd_en = 1;
    for (int i = 0; i < 20; i++) begin
      wr_data = DW'({$urandom(), $urandom()});
      tick();
      total++;
      if ({if1.level, if1.rd_data, if0.rd_data} !== {5'd8, exp_head(), m_rdd0}) begin
        bad++; $display("FAIL b2b_%0d got lvl=%0d h=%h d0=%h want 8 %h %h", i, if1.level, if1.rd_data,
          if0.rd_data, exp_head(), m_rdd0);
      end
    end
    wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({if0.rd_valid, if0.rd_data, if1.level} !== {1'b1, m_rdd0, 5'(7 - i)}) begin
        bad++; $display("FAIL b2b_drain_%0d got v=%b d=%h lvl=%0d want 1 %h %0d", i, if0.rd_valid,
          if0.rd_data, if1.level, m_rdd0, 7 - i);
      end
    end
    rd_en = 0;
  endtask

  task automatic test_random();
    int wp;
    for (int c = 0; c < 400; c++) begin
      wp = (c < 200) ? 70 : 30;
      wr_en   = ($urandom_range(0, 99) < wp);
      rd_en   = ($urandom_range(0, 99) < 100 - wp);
      flush   = ($urandom_range(0, 99) < 2);
      clr_err = ($urandom_range(0, 99) < 5);
      wr_data = DW'({$urandom(), $urandom()});
      tick();
      total++;
      if ({if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow, if1.level,
           if1.rd_valid, if1.rd_data} !== {exp_flags(), m_q.size() > 0, exp_head()}) begin
        bad++; $display("FAIL rand_fwft_%0d got %b v=%b d=%h want %b v=%b d=%h", c,
          {if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow, if1.level},
          if1.rd_valid, if1.rd_data, exp_flags(), m_q.size() > 0, exp_head());
      end
      total++;
      if ({if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow, if0.level,
           if0.rd_valid, if0.rd_data} !== {exp_flags(), m_rdv0, m_rdd0}) begin
        bad++; $display("FAIL rand_std_%0d got %b v=%b d=%h want %b v=%b d=%h", c,
          {if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow, if0.level},
          if0.rd_valid, if0.rd_data, exp_flags(), m_rdv0, m_rdd0);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    flush = 1; tick(); flush = 0;
    wr_en = 1;
    for (int i = 0; i < 7; i++) begin wr_data = DW'(32'h800 + i); tick(); end
    rd_en = 1; wr_data = DW'(32'h900);
    tick();
    total++;
    if (if1.level !== 5'd7) begin
      bad++; $display("FAIL pre_reset_level got %0d want 7", if1.level);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if ({if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow, if1.level,
         if1.rd_valid, if0.rd_valid, if0.level, if1.rd_data, if0.rd_data} !==
        {11'b0_1_0_1_0_0_00000, 1'b0, 1'b0, 5'd0, DW'(0), DW'(0)}) begin
      bad++; $display("FAIL async_reset got lvl=%0d/%0d e=%b v=%b/%b d0=%h", if1.level, if0.level,
        if1.empty, if1.rd_valid, if0.rd_valid, if0.rd_data);
    end
    idle();
    tick();
    rst_n = 1;
    tick();
    total++;
    if ({if1.empty, if1.level} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL post_reset got e=%b lvl=%0d want 1 0", if1.empty, if1.level);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_full_rw();
    test_flush();
    test_fwft();
    test_std();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
